// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// Results are computed at accept and held in buffers until the Busy window ends.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     hi_buf_q, lo_buf_q;
    logic            commit_q;

    logic            signed_op;
    logic [63:0]     a_ext, b_ext, prod_d;
    logic            a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, b_div;
    logic [31:0]     q_mag, r_mag, quo_d, rem_d;

    // Division works on magnitudes, so the signed overflow case falls out as
    // LO=0x80000000, HI=0 and a zero divisor never reaches the divider.
    always_comb begin
        signed_op = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        a_ext     = {signed_op ? {32{A[31]}} : 32'h0, A};
        b_ext     = {signed_op ? {32{B[31]}} : 32'h0, B};
        prod_d    = a_ext * b_ext;

        a_neg     = signed_op & A[31];
        b_neg     = signed_op & B[31];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        b_div     = (B == 32'h0) ? 32'h1 : b_mag;
        q_mag     = a_mag / b_div;
        r_mag     = a_mag % b_div;
        quo_d     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem_d     = a_neg ? -r_mag : r_mag;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_buf_q <= '0;
            lo_buf_q <= '0;
            commit_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                hi_buf_q <= prod_d[63:32];
                                lo_buf_q <= prod_d[31:0];
                                commit_q <= 1'b1;
                                cnt_q    <= CW'(MULT_CYCLES);
                                state_q  <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                // A zero divisor still takes the full window but commits nothing.
                                if (B != 32'h0) begin
                                    hi_buf_q <= rem_d;
                                    lo_buf_q <= quo_d;
                                end
                                commit_q <= (B != 32'h0);
                                cnt_q    <= CW'(DIV_CYCLES);
                                state_q  <= RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(1)) begin
                        if (commit_q) begin
                            hi_q <= hi_buf_q;
                            lo_q <= lo_buf_q;
                        end
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases then random back-to-back ops
// against a 64-bit arithmetic reference of HI/LO and the Busy window length.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi, exp_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns the expected Busy length.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, r64, q64;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        lat = 0;
        case (op)
            3'd0: begin r64 = 64'(sa * sb); exp_hi = r64[63:32]; exp_lo = r64[31:0]; lat = MULT_N; end
            3'd1: begin r64 = ua * ub;      exp_hi = r64[63:32]; exp_lo = r64[31:0]; lat = MULT_N; end
            3'd2: begin
                lat = DIV_N;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    q64 = 64'(sq); r64 = 64'(sr);
                    exp_lo = q64[31:0]; exp_hi = r64[31:0];
                end
            end
            3'd3: begin
                lat = DIV_N;
                if (b != 0) begin
                    q64 = ua / ub; r64 = ua % ub;
                    exp_lo = q64[31:0]; exp_hi = r64[31:0];
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge, count Busy cycles (bounded), optionally
    // assert an intruding Start during busy cycle 'intrude', then check HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int intrude, input logic [2:0] iop, input logic [31:0] ia);
        int n;
        int lat;
        model_op(op, a, b, lat);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Busy && n < 200) begin
            n++;
            if (n == intrude) begin
                Start = 1'b1; MDOp = iop; A = ia; B = $urandom;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        check($sformatf("busy_len op%0d", op), 64'(n), 64'(lat));
        check($sformatf("hi op%0d", op), {32'h0, HI}, {32'h0, exp_hi});
        check($sformatf("lo op%0d", op), {32'h0, LO}, {32'h0, exp_lo});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {63'h0, Busy}, 64'h0);
        check("reset hi", {32'h0, HI}, 64'h0);
        check("reset lo", {32'h0, LO}, 64'h0);

        // Directed cases from the plan
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 3'd0, 32'h0);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 0, 3'd0, 32'h0);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 3'd0, 32'h0);
        run_op(3'd4, 32'h12345678, 32'h0, 0, 3'd0, 32'h0);
        run_op(3'd5, 32'h9ABCDEF0, 32'h0, 0, 3'd0, 32'h0);
        run_op(3'd3, 32'd7, 32'd0, 0, 3'd0, 32'h0);
        check("divz keeps hi", {32'h0, HI}, 64'h12345678);
        check("divz keeps lo", {32'h0, LO}, 64'h9ABCDEF0);
        run_op(3'd3, 32'd100, 32'd7, 3, 3'd5, 32'hDEADBEEF);
        check("intrude lo", {32'h0, LO}, 64'd14);
        check("intrude hi", {32'h0, HI}, 64'd2);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'h0);
        check("ovf lo", {32'h0, LO}, 64'h80000000);
        check("ovf hi", {32'h0, HI}, 64'h0);
        run_op(3'd6, 32'hCAFEF00D, 32'h1, 0, 3'd0, 32'h0);

        // Reset during busy cycle 2 aborts the mult
        Start = 1'b1; MDOp = 3'd0; A = 32'd3; B = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        check("abort busy1", {63'h0, Busy}, 64'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("abort busy", {63'h0, Busy}, 64'h0);
        check("abort hi", {32'h0, HI}, 64'h0);
        check("abort lo", {32'h0, LO}, 64'h0);
        repeat (MULT_N + 2) @(negedge clk);
        check("abort no commit hi", {32'h0, HI}, 64'h0);
        check("abort no commit lo", {32'h0, LO}, 64'h0);

        // Random back-to-back traffic with corner operands and intruding Starts
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 9));
            if (sel == 3) ra = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(rop, ra, rb, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0,
                   3'($urandom_range(0, 7)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core. Owns the HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Acts as the responder to the control unit. The control unit issues a Start strobe. This block answers with Busy.
- The hazard unit stalls D-stage mult/div/mfhi/mflo/mthi/mtlo instructions while (Start | Busy).

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle strobe from the E-stage control unit; qualifies MDOp, A, B.
- MDOp  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
- A  input  32  forwarded rs value from E stage.
- B  input  32  forwarded rt value from E stage.
- Busy  output  1  registered; high while a mult/div is in flight.
- HI  output  32  registered HI register (mfhi source).
- LO  output  32  registered LO register (mflo source).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values: Busy=0, HI=0, LO=0, internal counter=0, result buffers=0. Reset wins over every other input.
- Reset while Busy=1: aborts the operation. The pending result is discarded and HI/LO read 0 afterwards.
- States: IDLE (Busy=0) and RUN (Busy=1). The down-counter cnt selects between them.
- Accept condition: the edge where Start=1 and Busy=0. When Busy=1, Start is ignored for every MDOp, and HI/LO are not disturbed.
- mult/multu accepted:
  - Latch the 64-bit product into hiBuf:loBuf. mult is signed, multu is unsigned.
  - Set cnt=MULT_CYCLES and Busy=1.
- div/divu accepted:
  - Latch the quotient into loBuf and the remainder into hiBuf.
  - div is signed, truncating toward zero; the remainder takes the sign of the dividend. divu is unsigned.
  - Set cnt=DIV_CYCLES and Busy=1.
- Divide by zero (B==0): the same Busy window still occurs. At completion HI/LO keep their prior values; no buffer commit.
- Signed overflow 0x80000000/-1: LO=0x80000000, HI=0.
- RUN: each edge decrements cnt. On the edge where cnt==1, HI<=hiBuf, LO<=loBuf, Busy<=0 and cnt<=0.
- Timing: Busy is high for exactly N cycles after the accept edge, where N=MULT_CYCLES or DIV_CYCLES. The new HI/LO are visible in the first cycle Busy reads 0.
- mthi/mtlo accepted: HI<=A (mthi) or LO<=A (mtlo) at the accept edge. Busy stays 0; no latency.
- MDOp 6-7 with Start: no state change.
- Back-to-back: a Start in the same cycle Busy first reads 0 is accepted, so zero idle cycles are required between operations.
- Outputs are pure register outputs; there is no combinational path from inputs to Busy/HI/LO.
- The block does not track flush. The control unit must never assert Start for a bubbled/flushed E instruction.

Test Plan:
- Reset, then mult A=0xFFFFFFFD(-3) B=5. Required: Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF B=2. Required: after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE. Then div A=0xFFFFFFF9(-7) B=2 started in the first non-busy cycle. Required: Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0. Required: HI/LO update at each accept edge with Busy=0 throughout. Then divu A=7 B=0. Required: 10 busy cycles, after which HI=0x12345678, LO=0x9ABCDEF0 are unchanged.
- divu A=100 B=7, then mtlo A=0xDEADBEEF with Start asserted in busy cycle 3. Required: the mtlo is ignored; final LO=14, HI=2.
- mult A=3 B=4, then reset asserted in busy cycle 2. Required: the next cycle reads Busy=0, HI=0, LO=0, and no later HI/LO commit occurs.
- div A=0x80000000 B=0xFFFFFFFF. Required: LO=0x80000000, HI=0. Also check Start with MDOp=6: required no state change.
